oam_dma_arbiter: RTL and testbench



---
 rtl/oam_dma_arbiter.sv | 177 +++++++++++++++++
 tb/tb_oam_dma_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter
// Owns the single memory-map port. Arbitrates CPU accesses against the OAM
// DMA copy engine, applies PPU-mode blocking to VRAM/OAM, and implements
// the 0xFF46 DMA source register.
module oam_dma_arbiter #(
    parameter int          DMA_LEN  = 160,
    parameter logic [15:0] OAM_BASE = 16'hFE00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wren,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    input  logic [1:0]  ppu_mode,
    input  logic        lcd_on,
    output logic [15:0] mem_addr,
    output logic        mem_wren,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        dma_active
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RD    = 2'd2,
        ST_WR    = 2'd3
    } state_t;

    localparam logic [7:0]  LAST_IDX = 8'(DMA_LEN - 1);
    localparam logic [15:0] DMA_REG  = 16'hFF46;

    // Inclusive address-window test used by every decoder below
    function automatic logic in_range(input logic [15:0] a,
                                      input logic [15:0] lo,
                                      input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

    state_t     state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] dma_src_q, dma_src_d;
    logic [7:0] dma_data_q, dma_data_d;
    logic       wr_first_q, wr_first_d;
    logic       blk_q, blk_d;
    logic       src_rd_q, src_rd_d;

    logic hram_s, trig_s, ppu_blk_s, dma_bus_s, cpu_owns_s, served_s;

    // Classify the CPU request: HRAM, DMA trigger, PPU blocking and port ownership
    always_comb begin
        hram_s     = in_range(cpu_addr, 16'hFF80, 16'hFFFE);
        trig_s     = cpu_wren && (cpu_addr == DMA_REG);
        ppu_blk_s  = lcd_on &&
                     ((in_range(cpu_addr, 16'h8000, 16'h9FFF) && (ppu_mode == 2'd3)) ||
                      (in_range(cpu_addr, 16'hFE00, 16'hFE9F) && ppu_mode[1]));
        // START leaves the port free; only RD/WR actually use it
        dma_bus_s  = (state_q == ST_RD) || (state_q == ST_WR);
        cpu_owns_s = !dma_bus_s || hram_s || trig_s;
        served_s   = cpu_owns_s && !ppu_blk_s;
    end

    // Drive the memory port from the CPU or the DMA engine, and the CPU read mux
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wren  = cpu_wren & ~ppu_blk_s;
        mem_wdata = cpu_wdata;
        if (!cpu_owns_s) begin
            if (state_q == ST_RD) begin
                mem_addr = {dma_src_q, 8'h00} + {8'h00, idx_q};
                mem_wren = 1'b0;
            end else begin
                mem_addr = OAM_BASE + {8'h00, idx_q};
                mem_wren = 1'b1;
                // Read data arrives during the first WR cycle; a later WR cycle
                // (after an HRAM stall) uses the copy captured then
                if (wr_first_q) begin
                    mem_wdata = mem_rdata;
                end else begin
                    mem_wdata = dma_data_q;
                end
            end
        end else begin
            mem_addr = cpu_addr;
        end

        // The DMA register is local, so its read never depends on port ownership
        if (src_rd_q) begin
            cpu_rdata = dma_src_q;
        end else if (blk_q) begin
            cpu_rdata = 8'hFF;
        end else begin
            cpu_rdata = mem_rdata;
        end

        dma_active = (state_q != ST_IDLE);
    end

    // Next-state logic for the copy sequencer and the read-return flags
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dma_src_d  = dma_src_q;
        dma_data_d = dma_data_q;
        wr_first_d = 1'b0;
        blk_d      = ~cpu_wren & ~served_s;
        src_rd_d   = ~cpu_wren & (cpu_addr == DMA_REG);

        if ((state_q == ST_WR) && wr_first_q) begin
            dma_data_d = mem_rdata;
        end else begin
            dma_data_d = dma_data_q;
        end

        if (trig_s) begin
            // A write to the DMA register restarts the copy from any state
            state_d   = ST_START;
            idx_d     = 8'd0;
            dma_src_d = cpu_wdata;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_START: begin
                    state_d = ST_RD;
                end
                ST_RD: begin
                    if (!cpu_owns_s) begin
                        state_d    = ST_WR;
                        wr_first_d = 1'b1;
                    end else begin
                        state_d = ST_RD;
                    end
                end
                ST_WR: begin
                    if (!cpu_owns_s) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_IDLE;
                        end else begin
                            idx_d   = idx_q + 8'd1;
                            state_d = ST_RD;
                        end
                    end else begin
                        state_d = ST_WR;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= 8'd0;
            dma_src_q  <= 8'h00;
            dma_data_q <= 8'h00;
            wr_first_q <= 1'b0;
            blk_q      <= 1'b0;
            src_rd_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            dma_src_q  <= dma_src_d;
            dma_data_q <= dma_data_d;
            wr_first_q <= wr_first_d;
            blk_q      <= blk_d;
            src_rd_q   <= src_rd_d;
        end
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Self-checking bench for oam_dma_arbiter: a 64 KiB synchronous memory, a
// transaction-level reference model checked every cycle, directed DMA
// scenarios and a randomized traffic phase.
module tb_oam_dma_arbiter;

    localparam int          DMA_LEN  = 160;
    localparam logic [15:0] OAM_BASE = 16'hFE00;

    logic        clock;
    logic        reset;
    logic [15:0] cpu_addr;
    logic        cpu_wren;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic [1:0]  ppu_mode;
    logic        lcd_on;
    logic [15:0] mem_addr;
    logic        mem_wren;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        dma_active;

    int n_checks = 0;
    int n_pass   = 0;

    oam_dma_arbiter #(.DMA_LEN(DMA_LEN), .OAM_BASE(OAM_BASE)) dut (
        .clock(clock), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wren(cpu_wren), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .ppu_mode(ppu_mode), .lcd_on(lcd_on),
        .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dma_active(dma_active)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Initial memory image: known pattern at 0xC000..0xC09F and 0xFF90
    function automatic logic [7:0] pre(input logic [15:0] a);
        logic [7:0] t;
        if (a >= 16'hC000 && a <= 16'hC09F) return a[7:0] ^ 8'h5A;
        if (a == 16'hFF90) return 8'h3C;
        t = a[7:0] * 8'd7;
        return t ^ a[15:8] ^ 8'h21;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    endtask

    // Synchronous memory, one cycle read latency, read-before-write
    logic [7:0] mem [0:65535];
    logic [7:0] mem_rq = 8'h00;
    assign mem_rdata = mem_rq;
    initial begin : memory
        for (int i = 0; i < 65536; i++) mem[i] = pre(16'(i));
        forever begin
            @(posedge clock);
            mem_rq <= mem[mem_addr];
            if (mem_wren) mem[mem_addr] = mem_wdata;
        end
    end

    // Reference model: DMA progress as a count k of port-using cycles since the
    // trigger (k=0 start, odd k reads byte (k-1)/2, even k writes byte (k-2)/2)
    logic [7:0] ref_mem [0:65535];
    bit         m_active;
    int         m_k;
    int         m_rkind;   // 0 memory value, 1 DMA register, 2 blocked, 3 unchecked
    logic [7:0] m_src, m_rdval, m_rval;

    initial begin : model
        logic [15:0] a, e_addr;
        logic [7:0]  d, e_wdata, e_rd;
        logic        w, hram, trig, pblk, owns, e_wren;
        for (int i = 0; i < 65536; i++) ref_mem[i] = pre(16'(i));
        m_active = 1'b0; m_k = 0; m_rkind = 3; m_src = 8'h00; m_rdval = 8'h00; m_rval = 8'h00;
        forever begin
            @(negedge clock);
            if (reset) begin
                m_active = 1'b0; m_k = 0; m_src = 8'h00; m_rkind = 3;
            end else begin
                a = cpu_addr; w = cpu_wren; d = cpu_wdata;
                hram = (a >= 16'hFF80) && (a <= 16'hFFFE);
                trig = w && (a == 16'hFF46);
                pblk = lcd_on && (((a >= 16'h8000) && (a <= 16'h9FFF) && (ppu_mode == 2'd3)) ||
                                  ((a >= 16'hFE00) && (a <= 16'hFE9F) && (ppu_mode >= 2'd2)));
                owns = !(m_active && (m_k > 0)) || hram || trig;
                if (owns) begin
                    e_addr = a; e_wren = w && !pblk; e_wdata = d;
                end else if ((m_k % 2) == 1) begin
                    e_addr = {m_src, 8'h00} + 16'((m_k - 1) / 2); e_wren = 1'b0; e_wdata = d;
                end else begin
                    e_addr = OAM_BASE + 16'((m_k - 2) / 2); e_wren = 1'b1; e_wdata = m_rdval;
                end
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_wren", mem_wren, e_wren);
                if (e_wren) chk("mem_wdata", mem_wdata, e_wdata);
                chk("dma_active", dma_active, m_active);
                if (m_rkind != 3) begin
                    e_rd = (m_rkind == 1) ? m_src : ((m_rkind == 2) ? 8'hFF : m_rval);
                    chk("cpu_rdata", cpu_rdata, e_rd);
                end
                // advance the model across the coming edge
                if (w) m_rkind = 3;
                else if (a == 16'hFF46) m_rkind = 1;
                else if (owns && !pblk) begin m_rkind = 0; m_rval = ref_mem[a]; end
                else m_rkind = 2;
                if (!owns && ((m_k % 2) == 1)) m_rdval = ref_mem[e_addr];
                if (e_wren) ref_mem[e_addr] = e_wdata;
                if (trig) begin
                    m_active = 1'b1; m_k = 0; m_src = d;
                end else if (m_active) begin
                    if (m_k == 0) m_k = 1;
                    else if (!owns) begin
                        if (m_k == 2 * DMA_LEN) m_active = 1'b0;
                        else m_k++;
                    end
                end
            end
        end
    end

    task automatic step(input logic [15:0] a, input logic w, input logic [7:0] d);
        cpu_addr = a; cpu_wren = w; cpu_wdata = d;
        @(posedge clock); #2;
    endtask

    // Trigger a DMA from src and run scenario-specific CPU traffic until it ends
    task automatic run_dma(input int scen, input logic [7:0] src, output int n);
        bit restarted;
        restarted = 1'b0;
        step(16'hFF46, 1'b1, src);
        n = 0;
        while (dma_active && n < 2000) begin
            if (scen == 4 && n == 161) begin
                reset = 1'b1;
                #1;
                chk("reset_mid_dma_active", dma_active, 1'b0);
                @(posedge clock); #2;
                reset = 1'b0;
                return;
            end
            if (scen == 1 && n == 20) step(16'hC010, 1'b0, 8'h00);
            else if (scen == 1 && n == 21) step(16'hD000, 1'b1, 8'h77);
            else if (scen == 2 && n >= 30 && n <= 39) step(16'hFF90, 1'b0, 8'h00);
            else if (scen == 3 && n == 101 && !restarted) begin
                step(16'hFF46, 1'b1, 8'hD0);
                restarted = 1'b1;
                n = -1;
            end
            else step(16'h0000, 1'b0, 8'h00);
            if (scen == 1 && n == 20) chk("dma_blocked_read", cpu_rdata, 8'hFF);
            if (scen == 2 && n == 30) chk("hram_read", cpu_rdata, 8'h3C);
            n++;
        end
    endtask

    function automatic int oam_errs(input logic [15:0] src_base);
        int e;
        e = 0;
        for (int i = 0; i < DMA_LEN; i++)
            if (mem[OAM_BASE + 16'(i)] !== pre(src_base + 16'(i))) e++;
        return e;
    endfunction

    initial begin : stim
        int n, errs, cls;
        logic [15:0] a;
        logic        w;
        logic [7:0]  d;

        reset = 1'b1; cpu_addr = 16'h1234; cpu_wren = 1'b1; cpu_wdata = 8'h5A;
        ppu_mode = 2'd0; lcd_on = 1'b0;
        #1;
        chk("reset_dma_active", dma_active, 1'b0);
        chk("reset_mem_addr", mem_addr, 16'h1234);
        chk("reset_mem_wren", mem_wren, 1'b1);
        chk("reset_mem_wdata", mem_wdata, 8'h5A);
        chk("reset_cpu_rdata", cpu_rdata, 8'h00);
        #1;
        cpu_addr = 16'h0000; cpu_wren = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
        step(16'hFF46, 1'b0, 8'h00);
        chk("src_reg_after_reset", cpu_rdata, 8'h00);

        // PPU blocking with DMA idle
        lcd_on = 1'b1; ppu_mode = 2'd3;
        step(16'h8000, 1'b1, 8'hAA);
        step(16'h8000, 1'b0, 8'h00);
        chk("vram_mode3_read", cpu_rdata, 8'hFF);
        chk("vram_mode3_write_dropped", mem[16'h8000], pre(16'h8000));
        ppu_mode = 2'd2;
        step(16'h8000, 1'b0, 8'h00);
        chk("vram_mode2_read", cpu_rdata, pre(16'h8000));
        step(16'hFE00, 1'b0, 8'h00);
        chk("oam_mode2_read", cpu_rdata, 8'hFF);
        lcd_on = 1'b0; ppu_mode = 2'd3;
        step(16'hFE00, 1'b0, 8'h00);
        chk("oam_lcd_off_read", cpu_rdata, pre(16'hFE00));
        ppu_mode = 2'd0;

        // Basic DMA
        run_dma(0, 8'hC0, n);
        chk("basic_len", n, 321);
        errs = 0;
        for (int i = 0; i < DMA_LEN; i++)
            if (mem[16'hFE00 + 16'(i)] !== (8'(i) ^ 8'h5A)) errs++;
        chk("basic_oam", errs, 0);
        step(16'hFF46, 1'b0, 8'h00);
        chk("src_reg_read", cpu_rdata, 8'hC0);

        // CPU blocked during DMA
        run_dma(1, 8'hC0, n);
        chk("blocking_len", n, 321);
        chk("blocked_write_dropped", mem[16'hD000], pre(16'hD000));

        // HRAM stalls
        run_dma(2, 8'hC0, n);
        chk("hram_stall_len", n, 331);
        chk("hram_stall_oam", oam_errs(16'hC000), 0);

        // Restart mid-transfer with a new source
        run_dma(3, 8'hC0, n);
        chk("restart_len", n, 321);
        chk("restart_oam", oam_errs(16'hD000), 0);

        // Reset mid-transfer
        run_dma(4, 8'hC0, n);
        step(16'hFF46, 1'b0, 8'h00);
        chk("src_reg_after_mid_reset", cpu_rdata, 8'h00);
        chk("idle_after_mid_reset", dma_active, 1'b0);

        // Randomized traffic with random DMAs, restarts, stalls and PPU modes
        for (int c = 0; c < 5000; c++) begin
            cls = int'($urandom_range(0, 7));
            ppu_mode = 2'($urandom_range(0, 3));
            lcd_on = 1'($urandom_range(0, 1));
            w = ($urandom_range(0, 2) == 0);
            d = 8'($urandom_range(0, 255));
            case (cls)
                0: a = 16'hFF80 + 16'($urandom_range(0, 126));
                1: a = 16'hC000 + 16'($urandom_range(0, 16'h1FFF));
                2: a = 16'h8000 + 16'($urandom_range(0, 16'h1FFF));
                3: a = 16'hFE00 + 16'($urandom_range(0, 16'h9F));
                4: begin a = 16'hFF46; w = 1'b0; end
                5: a = 16'($urandom_range(0, 16'hFFFF));
                default: a = 16'hC000 + 16'($urandom_range(0, 16'h1FFF));
            endcase
            if ((!dma_active && $urandom_range(0, 59) == 0) ||
                (dma_active && $urandom_range(0, 799) == 0)) begin
                a = 16'hFF46; w = 1'b1; d = 8'($urandom_range(16'h00C0, 16'h00DF));
            end
            step(a, w, d);
        end
        ppu_mode = 2'd0; lcd_on = 1'b0;
        step(16'h0000, 1'b0, 8'h00);

        errs = 0;
        for (int i = 0; i < 65536; i++)
            if (mem[i] !== ref_mem[i]) errs++;
        chk("memory_image", errs, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
